// File: rtl/data_sram_bridge.sv
// Bridges the M-stage single-cycle data port onto a split req/addr_ok + data_ok sram-like bus.
// Latency: zero-wait slave gives mem_stall high for 2 cycles and load data on mem_rdata in cycle 3.
// Backpressure: slave delays via addr_ok/data_ok; mem_stall freezes F..M until the response lands.
module data_sram_bridge #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    // M-stage side
    input  logic            mem_en,
    input  logic [DW/8-1:0] mem_wen,
    input  logic [1:0]      mem_size,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_wdata,
    input  logic            core_stall,
    input  logic            flush,
    output logic [DW-1:0]   mem_rdata,
    output logic            mem_stall,
    // sram-like bus side
    output logic            data_req,
    output logic            data_wr,
    output logic [1:0]      data_size,
    output logic [AW-1:0]   data_addr,
    output logic [DW-1:0]   data_wdata,
    input  logic            data_addr_ok,
    input  logic            data_data_ok,
    input  logic [DW-1:0]   data_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Everything the bus needs for one access, captured once at issue so the
    // bus never sees the M-stage inputs change underneath a pending request.
    typedef struct packed {
        logic            wr;
        logic [1:0]      size;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
    } req_t;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    req_t          req_q;
    logic          aborted;
    logic [DW-1:0] rdata_r;

    logic          issue;
    logic          abort_now;
    logic          resp_ok;

    // A new access starts only from IDLE; a flushed instruction never reaches the bus.
    assign issue = (state == IDLE) && mem_en && !flush;

    // A flush seen in the same cycle as the response counts as an abort too,
    // otherwise the cancelled load could still land in rdata_r.
    assign abort_now = aborted || flush;

    // Response for the single outstanding access. In ADDR the response only
    // counts together with addr_ok; data_ok in IDLE/DONE is ignored entirely.
    assign resp_ok = ((state == ADDR) && data_addr_ok && data_data_ok) ||
                     ((state == DATA) && data_data_ok);

    // Next-state selection; a completed but aborted access skips DONE so the
    // M stage never sees it as finished.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (data_addr_ok && data_data_ok) begin
                    state_nxt = abort_now ? IDLE : DONE;
                end else if (data_addr_ok) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (data_data_ok) begin
                    state_nxt = abort_now ? IDLE : DONE;
                end
            end
            DONE: begin
                if (!core_stall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset abandons any outstanding access since the slave resets with us.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request registers, loaded only on issue so they stay constant through ADDR and DATA.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q <= '0;
        end else if (issue) begin
            req_q.wr    <= |mem_wen;
            req_q.size  <= mem_size;
            req_q.addr  <= mem_addr;
            req_q.wdata <= mem_wdata;
        end
    end

    // Sticky abort: a request already on the bus cannot be withdrawn, so remember
    // the flush until the access drains and we are back in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aborted <= 1'b0;
        end else if (state_nxt == IDLE) begin
            aborted <= 1'b0;
        end else if (((state == ADDR) || (state == DATA)) && flush) begin
            aborted <= 1'b1;
        end
    end

    // Load result register; stores and aborted loads leave the previous value in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= '0;
        end else if (resp_ok && !req_q.wr && !abort_now) begin
            rdata_r <= data_rdata;
        end
    end

    assign mem_rdata  = rdata_r;

    // DONE releases the pipeline; IDLE only stalls on the cycle it issues.
    assign mem_stall  = issue || (state == ADDR) || (state == DATA);

    // Bus side comes purely from registers: req from the state, the rest from req_q.
    assign data_req   = (state == ADDR);
    assign data_wr    = req_q.wr;
    assign data_size  = req_q.size;
    assign data_addr  = req_q.addr;
    assign data_wdata = req_q.wdata;

endmodule

// File: tb/tb_data_sram_bridge.sv
module tb_data_sram_bridge;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_stall;
    logic        flush;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int errors;
    int checks;

    // expected mem_rdata values, pushed when an access is launched
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    // slave model configuration
    logic        sl_en;
    int          sl_addr_wait;
    int          sl_data_wait;
    logic [31:0] sl_rdata;

    data_sram_bridge #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_stall   (core_stall),
        .flush        (flush),
        .mem_rdata    (mem_rdata),
        .mem_stall    (mem_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sram-like slave: addr_ok after sl_addr_wait request cycles, data_ok sl_data_wait cycles later
    initial begin
        int  a_cnt;
        int  d_cnt;
        bit  pend;
        a_cnt = 0; d_cnt = 0; pend = 0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                pend  = 0;
                a_cnt = 0;
            end
            if (sl_en) begin
                data_addr_ok = 1'b0;
                data_data_ok = 1'b0;
                if (pend) begin
                    if (d_cnt == 0) begin
                        data_data_ok = 1'b1;
                        data_rdata   = sl_rdata;
                        pend         = 0;
                    end else begin
                        d_cnt--;
                    end
                end else if (data_req) begin
                    if (a_cnt == sl_addr_wait) begin
                        data_addr_ok = 1'b1;
                        a_cnt        = 0;
                        if (sl_data_wait == 0) begin
                            data_data_ok = 1'b1;
                            data_rdata   = sl_rdata;
                        end else begin
                            pend  = 1;
                            d_cnt = sl_data_wait - 1;
                        end
                    end else begin
                        a_cnt++;
                    end
                end else begin
                    a_cnt = 0;
                end
            end
        end
    end

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() > 0) return exp_q.pop_front();
        return 32'hxxxx_xxxx;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", data_req); end
        checks++; if (data_wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b want 0", data_wr); end
        checks++; if (data_size !== 2'd0) begin errors++; $display("FAIL rst_size: got %0d want 0", data_size); end
        checks++; if (data_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", data_addr); end
        checks++; if (data_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", data_wdata); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", mem_rdata); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", mem_stall); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        last_rd = 32'h0;
    endtask

    task automatic test_zero_wait_load();
        int req_n, stall_n, done_cyc;
        logic [31:0] exp;
        req_n = 0; stall_n = 0; done_cyc = 0;
        @(posedge clk); #1;
        sl_addr_wait = 0; sl_data_wait = 0; sl_rdata = 32'hDEAD_BEEF;
        mem_en = 1'b1; mem_wen = 4'b0000; mem_size = 2'd2;
        mem_addr = 32'h1000_0004; mem_wdata = 32'h0;
        exp_q.push_back(32'hDEAD_BEEF);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            if (data_req) req_n++;
            if (mem_stall) stall_n++;
            if (c > 1 && !mem_stall) begin done_cyc = c; break; end
        end
        exp = pop_exp();
        checks++; if (req_n !== 1) begin errors++; $display("FAIL zw_req_cycles: got %0d want 1", req_n); end
        checks++; if (stall_n !== 2) begin errors++; $display("FAIL zw_stall_cycles: got %0d want 2", stall_n); end
        checks++; if (done_cyc !== 3) begin errors++; $display("FAIL zw_done_cycle: got %0d want 3", done_cyc); end
        checks++; if (mem_rdata !== exp) begin errors++; $display("FAIL zw_rdata: got %h want %h", mem_rdata, exp); end
        last_rd = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_en = 1'b0;
    endtask

    task automatic test_wait_store();
        int req_n, stall_n, done_cyc, bad;
        logic [31:0] exp;
        req_n = 0; stall_n = 0; done_cyc = 0; bad = 0;
        @(posedge clk); #1;
        sl_addr_wait = 3; sl_data_wait = 2; sl_rdata = 32'hFFFF_FFFF;
        mem_en = 1'b1; mem_wen = 4'b0011; mem_size = 2'd1;
        mem_addr = 32'h1000_0010; mem_wdata = 32'h0000_1234;
        exp_q.push_back(last_rd);
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == 2) begin
                // M-stage inputs move on; the bus must keep the latched request
                mem_addr = 32'hAAAA_AAAA; mem_wdata = 32'h5555_5555;
            end
            @(negedge clk);
            if (data_req) begin
                req_n++;
                if (data_addr !== 32'h1000_0010 || data_wdata !== 32'h0000_1234 ||
                    data_wr !== 1'b1 || data_size !== 2'd1) bad++;
            end
            if (mem_stall) stall_n++;
            if (c > 1 && !mem_stall) begin done_cyc = c; break; end
        end
        exp = pop_exp();
        checks++; if (req_n !== 4) begin errors++; $display("FAIL st_req_cycles: got %0d want 4", req_n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL st_bus_stable: got %0d unstable cycles want 0", bad); end
        checks++; if (stall_n !== 7) begin errors++; $display("FAIL st_stall_cycles: got %0d want 7", stall_n); end
        checks++; if (done_cyc !== 8) begin errors++; $display("FAIL st_done_cycle: got %0d want 8", done_cyc); end
        checks++; if (mem_rdata !== exp) begin errors++; $display("FAIL st_rdata_kept: got %h want %h", mem_rdata, exp); end
        @(posedge clk); #1;
        mem_en = 1'b0; mem_wen = 4'b0000;
    endtask

    task automatic test_done_hold();
        int done_cyc, bad, n;
        logic [31:0] exp;
        done_cyc = 0; bad = 0; n = 0;
        @(posedge clk); #1;
        sl_addr_wait = 0; sl_data_wait = 0; sl_rdata = 32'hCAFE_F00D;
        core_stall = 1'b1;
        mem_en = 1'b1; mem_wen = 4'b0000; mem_size = 2'd2; mem_addr = 32'h0000_2000;
        exp_q.push_back(32'hCAFE_F00D);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            if (c > 1 && !mem_stall) begin done_cyc = c; break; end
        end
        exp = pop_exp();
        checks++; if (done_cyc !== 3) begin errors++; $display("FAIL hold_done_cycle: got %0d want 3", done_cyc); end
        checks++; if (mem_rdata !== exp) begin errors++; $display("FAIL hold_rdata: got %h want %h", mem_rdata, exp); end
        last_rd = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (data_req !== 1'b0 || mem_stall !== 1'b0 || mem_rdata !== last_rd) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_quiet: got %0d bad cycles want 0", bad); end
        // release: this cycle still DONE, next cycle IDLE re-issues with mem_en high
        @(posedge clk); #1;
        core_stall = 1'b0;
        @(negedge clk);
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL hold_release_stall: got %b want 0", mem_stall); end
        @(posedge clk); #1;
        sl_rdata = 32'h0BAD_F00D;
        exp_q.push_back(32'h0BAD_F00D);
        @(negedge clk);
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL hold_idle_issue: got %b want 1", mem_stall); end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
            if (!mem_stall) break;
        end
        exp = pop_exp();
        checks++; if (n !== 2) begin errors++; $display("FAIL hold_reissue_len: got %0d want 2", n); end
        checks++; if (mem_rdata !== exp) begin errors++; $display("FAIL hold_reissue_rdata: got %h want %h", mem_rdata, exp); end
        last_rd = 32'h0BAD_F00D;
        @(posedge clk); #1;
        mem_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0]  req_v, stall_v;
        logic [31:0] exp;
        int bad_hold;
        req_v = '0; stall_v = '0; bad_hold = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                sl_addr_wait = 0; sl_data_wait = 0; sl_rdata = 32'h0000_0011;
                mem_en = 1'b1; mem_wen = 4'b0000; mem_size = 2'd2; mem_addr = 32'h0;
                exp_q.push_back(32'h0000_0011);
            end
            if (c == 4) begin
                mem_addr = 32'h0000_0004; sl_rdata = 32'h0000_0022;
                exp_q.push_back(32'h0000_0022);
            end
            @(negedge clk);
            req_v[c-1]   = data_req;
            stall_v[c-1] = mem_stall;
            if (c == 3 || c == 6) begin
                exp = pop_exp();
                checks++; if (mem_rdata !== exp) begin errors++; $display("FAIL b2b_rdata_c%0d: got %h want %h", c, mem_rdata, exp); end
            end
            if ((c == 4 || c == 5) && mem_rdata !== 32'h0000_0011) bad_hold++;
            if (c == 5) begin
                checks++; if (data_addr !== 32'h0000_0004) begin errors++; $display("FAIL b2b_addr2: got %h want 00000004", data_addr); end
            end
        end
        checks++; if (req_v !== 6'b010010) begin errors++; $display("FAIL b2b_req_pattern: got %b want 010010", req_v); end
        checks++; if (stall_v !== 6'b011011) begin errors++; $display("FAIL b2b_stall_pattern: got %b want 011011", stall_v); end
        checks++; if (bad_hold !== 0) begin errors++; $display("FAIL b2b_rdata_hold: got %0d bad cycles want 0", bad_hold); end
        last_rd = 32'h0000_0022;
        @(posedge clk); #1;
        mem_en = 1'b0;
    endtask

    task automatic test_flush_addr();
        int req_n, done_cyc, n;
        logic [31:0] exp;
        req_n = 0; done_cyc = 0; n = 0;
        @(posedge clk); #1;
        sl_addr_wait = 3; sl_data_wait = 2; sl_rdata = 32'h0000_0055;
        mem_en = 1'b1; mem_wen = 4'b0000; mem_size = 2'd2; mem_addr = 32'h0000_3000;
        exp_q.push_back(last_rd);
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == 3) begin flush = 1'b1; mem_en = 1'b0; end
            if (c == 4) flush = 1'b0;
            @(negedge clk);
            if (data_req) req_n++;
            if (c > 1 && !mem_stall) begin done_cyc = c; break; end
        end
        exp = pop_exp();
        checks++; if (req_n !== 4) begin errors++; $display("FAIL fl_req_held: got %0d want 4", req_n); end
        checks++; if (done_cyc !== 8) begin errors++; $display("FAIL fl_end_cycle: got %0d want 8", done_cyc); end
        checks++; if (mem_rdata !== exp) begin errors++; $display("FAIL fl_rdata_kept: got %h want %h", mem_rdata, exp); end
        // back in IDLE (not DONE): a fresh access stalls immediately and completes normally
        @(posedge clk); #1;
        sl_addr_wait = 0; sl_data_wait = 0; sl_rdata = 32'h0000_0066;
        mem_en = 1'b1; mem_addr = 32'h0000_3004;
        exp_q.push_back(32'h0000_0066);
        @(negedge clk);
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL fl_idle_after: got %b want 1", mem_stall); end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
            if (!mem_stall) break;
        end
        exp = pop_exp();
        checks++; if (n !== 2) begin errors++; $display("FAIL fl_next_len: got %0d want 2", n); end
        checks++; if (mem_rdata !== exp) begin errors++; $display("FAIL fl_abort_cleared: got %h want %h", mem_rdata, exp); end
        last_rd = 32'h0000_0066;
        @(posedge clk); #1;
        mem_en = 1'b0;
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        sl_addr_wait = 0; sl_data_wait = 5; sl_rdata = 32'h0000_0077;
        mem_en = 1'b1; mem_wen = 4'b0000; mem_size = 2'd2; mem_addr = 32'h0000_4000;
        @(posedge clk); #1;
        mem_en = 1'b0;          // dropped early: the bridge still finishes the access
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (mem_stall !== 1'b1 || data_req !== 1'b0) begin errors++;
            $display("FAIL ar_in_data: got stall=%b req=%b want stall=1 req=0", mem_stall, data_req); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL ar_stall: got %b want 0", mem_stall); end
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL ar_req: got %b want 0", data_req); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL ar_rdata: got %h want 0", mem_rdata); end
        @(posedge clk);
        @(negedge clk);
        sl_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        data_data_ok = 1'b1; data_rdata = 32'h0000_0099;
        @(negedge clk);
        checks++; if (mem_stall !== 1'b0 || data_req !== 1'b0) begin errors++;
            $display("FAIL ar_late_ok: got stall=%b req=%b want 0 0", mem_stall, data_req); end
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        @(negedge clk);
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL ar_late_rdata: got %h want 0", mem_rdata); end
        sl_en = 1'b1;
    endtask

    initial begin
        errors = 0; checks = 0;
        sl_en = 1'b1; sl_addr_wait = 0; sl_data_wait = 0; sl_rdata = '0;
        mem_en = 1'b0; mem_wen = 4'b0000; mem_size = 2'd0;
        mem_addr = '0; mem_wdata = '0; core_stall = 1'b0; flush = 1'b0;
        rst = 1'b0;
        test_reset();
        test_zero_wait_load();
        test_wait_store();
        test_done_hold();
        test_back_to_back();
        test_flush_addr();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
